// File: rtl/modulo_controlador_display_mux_pkg.sv
// Shared types for the multiplexed 7-segment scanner: FSM states and BCD helpers.
package modulo_controlador_display_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic bcd_invalid(input logic [3:0] digit);
        return digit > BCD_MAX;
    endfunction

endpackage

// File: rtl/modulo_controlador_display_mux_varredura.sv
// Slot counter and digit index for the display scan; flags slot end and frame wrap.
module modulo_controlador_display_mux_varredura #(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        run,
    output logic [$clog2(SCAN_DIV)-1:0] cnt,
    output logic [$clog2(N_DIGITS)-1:0] idx,
    output logic [$clog2(N_DIGITS)-1:0] idx_nx,
    output logic                        slot_end,
    output logic                        wrap
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(N_DIGITS);

    logic [CNT_W-1:0] cnt_nx;

    assign slot_end = (cnt == CNT_W'(SCAN_DIV - 1));
    assign wrap     = slot_end && (idx == IDX_W'(N_DIGITS - 1));

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_nx = cnt;
        idx_nx = idx;
        if (clear) begin
            cnt_nx = '0;
            idx_nx = '0;
        end else if (run) begin
            if (slot_end) begin
                cnt_nx = '0;
                idx_nx = wrap ? '0 : idx + IDX_W'(1);
            end else begin
                cnt_nx = cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_nx;
            idx <= idx_nx;
        end
    end

endmodule

// File: rtl/modulo_controlador_display_mux.sv
// Multiplexed N-digit 7-segment scanner with double-buffered digits, anti-ghost guard and LZS.
module modulo_controlador_display_mux
    import modulo_controlador_display_mux_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int BLANK_GUARD = 2,
    parameter int ANODE_ACT   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lzs_en,
    output logic                  load_ack,
    output logic [3:0]            bcd_out,
    output logic                  blank_out,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   anode_out,
    output logic                  frame_done
);

    localparam int     CNT_W      = $clog2(SCAN_DIV);
    localparam int     IDX_W      = $clog2(N_DIGITS);
    localparam logic   ANODE_ON   = (ANODE_ACT != 0);
    localparam logic   ANODE_OFF  = !ANODE_ON;
    localparam state_t SLOT_START = (BLANK_GUARD == 0) ? ST_ON : ST_GUARD;

    state_t state, state_nx;

    logic [N_DIGITS-1:0][3:0] pend_digits, act_digits, act_digits_nx;
    logic [N_DIGITS-1:0]      pend_dp, act_dp, act_dp_nx;
    logic                     pend_valid;

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx, idx_nx;
    logic             slot_end, wrap, clear, run, frame_end, commit;

    logic [N_DIGITS-1:0] anode_nx, supp;
    logic [3:0]          bcd_nx;
    logic                blank_nx, dp_nx, zero_run;

    assign clear     = !enable || (state == ST_IDLE);
    assign run       = enable && (state != ST_IDLE);
    assign frame_end = run && wrap;
    assign commit    = (enable && (state == ST_IDLE)) || frame_end;

    modulo_controlador_display_mux_varredura #(
        .N_DIGITS (N_DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_varredura (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .run      (run),
        .cnt      (cnt),
        .idx      (idx),
        .idx_nx   (idx_nx),
        .slot_end (slot_end),
        .wrap     (wrap)
    );

    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:  state_nx = SLOT_START;
                ST_GUARD: if (cnt == CNT_W'(BLANK_GUARD - 1)) state_nx = ST_ON;
                ST_ON:    if (slot_end) state_nx = SLOT_START;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    // A load in the commit cycle still lands in pending; commit copies the older pending value.
    assign act_digits_nx = (commit && pend_valid) ? pend_digits : act_digits;
    assign act_dp_nx     = (commit && pend_valid) ? pend_dp     : act_dp;

    // Outputs are derived from next-state values so the registered outputs line up with the FSM.
    always_comb begin
        anode_nx = {N_DIGITS{ANODE_OFF}};
        bcd_nx   = '0;
        dp_nx    = 1'b0;
        blank_nx = 1'b1;
        supp     = '0;
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (act_digits_nx[i] == 4'd0);
            supp[i]  = zero_run;
        end
        if (state_nx != ST_IDLE) begin
            bcd_nx = act_digits_nx[idx_nx];
            dp_nx  = act_dp_nx[idx_nx];
        end
        if (state_nx == ST_ON) begin
            anode_nx[idx_nx] = ANODE_ON;
            blank_nx         = bcd_invalid(act_digits_nx[idx_nx]) || (lzs_en && supp[idx_nx]);
        end
    end

    // NOTE: the digit buffers are plain registers, so they take an explicit reset value like any flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_valid  <= 1'b0;
            act_digits  <= '0;
            act_dp      <= '0;
            load_ack    <= 1'b0;
            frame_done  <= 1'b0;
            anode_out   <= {N_DIGITS{ANODE_OFF}};
            bcd_out     <= '0;
            blank_out   <= 1'b1;
            dp_out      <= 1'b0;
        end else begin
            state      <= state_nx;
            act_digits <= act_digits_nx;
            act_dp     <= act_dp_nx;
            if (load) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
                pend_valid  <= 1'b1;
            end else if (commit) begin
                pend_valid <= 1'b0;
            end
            load_ack   <= load;
            frame_done <= frame_end;
            anode_out  <= anode_nx;
            bcd_out    <= bcd_nx;
            blank_out  <= blank_nx;
            dp_out     <= dp_nx;
        end
    end

endmodule
